// File: rtl/adder_result_accumulator_if.sv
// Handshake bundle between the adder stream, the block accumulator and its consumer.
// The slave modport is the accumulator's view; master is the surrounding logic.
interface adder_result_accumulator_if #(
    parameter int unsigned IN_W      = 5,
    parameter int unsigned BLOCK_LEN = 8,
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned CNT_W     = $clog2(BLOCK_LEN + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [IN_W-1:0]  out_max;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_acc, out_max, out_count, out_sat
    );

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_acc, out_max, out_count, out_sat
    );
endinterface

// File: rtl/adder_result_accumulator.sv
// Block accumulator for the 4-bit adder's 5-bit sums: totals BLOCK_LEN samples
// (or fewer on flush) and reports total, max, count and a sticky saturation flag.
module adder_result_accumulator #(
    parameter int unsigned IN_W      = 5,
    parameter int unsigned BLOCK_LEN = 8,
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned CNT_W     = $clog2(BLOCK_LEN + 1)
) (
    input logic                        clk,
    input logic                        rst,
    adder_result_accumulator_if.slave  bus
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    logic [0:0]       state_q,     state_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [IN_W-1:0]  max_q,       max_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             sat_q,       sat_d;
    logic [ACC_W-1:0] out_acc_q,   out_acc_d;
    logic [IN_W-1:0]  out_max_q,   out_max_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_sat_q,   out_sat_d;

    logic             in_fire;
    logic             out_fire;
    logic             close_block;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_upd;
    logic [IN_W-1:0]  max_upd;
    logic [CNT_W-1:0] cnt_upd;
    logic             sat_upd;

    // Handshake outputs come from the state register alone, never from inputs.
    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_acc   = out_acc_q;
    assign bus.out_max   = out_max_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;

    assign in_fire  = bus.in_valid && (state_q == ST_ACCUM);
    assign out_fire = bus.out_ready && (state_q == ST_HOLD);

    // Running values as they would be after accepting the current sample; the
    // extra top bit of sum_wide is the overflow that drives clamping and sat.
    assign sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(bus.in_data);
    assign acc_upd  = sum_wide[ACC_W] ? ACC_MAX : sum_wide[ACC_W-1:0];
    assign sat_upd  = sat_q | sum_wide[ACC_W];
    assign max_upd  = (bus.in_data > max_q) ? bus.in_data : max_q;
    assign cnt_upd  = cnt_q + CNT_W'(1);

    // A flush only closes a block that will hold at least one sample.
    assign close_block = (in_fire && (cnt_q == LAST_CNT))
                       || (bus.flush && ((cnt_q != '0) || in_fire));

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        acc_d       = acc_q;
        max_d       = max_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_acc_d   = out_acc_q;
        out_max_d   = out_max_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;

        case (state_q)
            ST_ACCUM: begin
                if (in_fire) begin
                    acc_d = acc_upd;
                    max_d = max_upd;
                    cnt_d = cnt_upd;
                    sat_d = sat_upd;
                end
                if (close_block) begin
                    state_d     = ST_HOLD;
                    out_acc_d   = acc_d;
                    out_max_d   = max_d;
                    out_count_d = cnt_d;
                    out_sat_d   = sat_d;
                end
            end
            ST_HOLD: begin
                // Inputs and flush are ignored here; the result stays frozen.
                if (out_fire) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    max_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            max_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_acc_q   <= '0;
            out_max_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            acc_q       <= acc_d;
            max_q       <= max_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_acc_q   <= out_acc_d;
            out_max_q   <= out_max_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench: table of per-cycle vectors plus hand-written multi-cycle sequences,
// with a second instance at ACC_W=6 to reach saturation.
module tb_adder_result_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    adder_result_accumulator_if #(.ACC_W(16)) bus ();
    adder_result_accumulator_if #(.ACC_W(6))  bus6 ();

    adder_result_accumulator #(.ACC_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    adder_result_accumulator #(.ACC_W(6)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6.slave)
    );

    typedef struct {
        logic        v;
        logic [4:0]  d;
        logic        f;
        logic        r;
        logic        rdy;
        logic        vld;
        logic [15:0] acc;
        logic [4:0]  mx;
        logic [3:0]  cnt;
        logic        sat;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [4:0] d, input logic f, input logic r);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = f;
        bus.out_ready = r;
    endtask

    task automatic tick6(input logic v, input logic [4:0] d, input logic f, input logic r);
        @(negedge clk);
        bus6.in_valid  = v;
        bus6.in_data   = d;
        bus6.flush     = f;
        bus6.out_ready = r;
    endtask

    task automatic expect_out(input string tag, input logic rdy, input logic vld,
                              input logic [15:0] acc, input logic [4:0] mx,
                              input logic [3:0] cnt, input logic sat);
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'(rdy));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
        check({tag, ".out_acc"},   32'(bus.out_acc),   32'(acc));
        check({tag, ".out_max"},   32'(bus.out_max),   32'(mx));
        check({tag, ".out_count"}, 32'(bus.out_count), 32'(cnt));
        check({tag, ".out_sat"},   32'(bus.out_sat),   32'(sat));
    endtask

    task automatic expect6(input string tag, input logic rdy, input logic vld,
                           input logic [5:0] acc, input logic [4:0] mx,
                           input logic [3:0] cnt, input logic sat);
        check({tag, ".in_ready"},  32'(bus6.in_ready),  32'(rdy));
        check({tag, ".out_valid"}, 32'(bus6.out_valid), 32'(vld));
        check({tag, ".out_acc"},   32'(bus6.out_acc),   32'(acc));
        check({tag, ".out_max"},   32'(bus6.out_max),   32'(mx));
        check({tag, ".out_count"}, 32'(bus6.out_count), 32'(cnt));
        check({tag, ".out_sat"},   32'(bus6.out_sat),   32'(sat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Block 1..8 (total 36), HOLD for one cycle, then 3 + seven 1s (total 10).
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 5'(i + 1), 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 5'd0, 4'd0, 1'b0};
        tbl[8] = '{1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 16'd36, 5'd8, 4'd8, 1'b0};
        tbl[9] = '{1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 16'd36, 5'd8, 4'd8, 1'b0};
        for (int i = 10; i < 17; i++)
            tbl[i] = '{1'b1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd36, 5'd8, 4'd8, 1'b0};
        tbl[17] = '{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd10, 5'd3, 4'd8, 1'b0};

        bus.in_valid = 1'b0;  bus.in_data = '0;  bus.flush = 1'b0;  bus.out_ready = 1'b1;
        bus6.in_valid = 1'b0; bus6.in_data = '0; bus6.flush = 1'b0; bus6.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table-driven: inputs for the cycle, outputs visible during that cycle.
        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
            expect_out($sformatf("tbl[%0d]", i), tbl[i].rdy, tbl[i].vld, tbl[i].acc,
                       tbl[i].mx, tbl[i].cnt, tbl[i].sat);
        end

        // Backpressure: eight 31s, result held while 7 waits upstream.
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 5'd31, 1'b0, 1'b0);
            expect_out($sformatf("bp_in[%0d]", i), 1'b1, 1'b0, 16'd10, 5'd3, 4'd8, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 5'd7, (i == 2), 1'b0);
            expect_out($sformatf("bp_hold[%0d]", i), 1'b0, 1'b1, 16'd248, 5'd31, 4'd8, 1'b0);
        end
        tick(1'b1, 5'd7, 1'b0, 1'b1);
        expect_out("bp_release", 1'b0, 1'b1, 16'd248, 5'd31, 4'd8, 1'b0);
        tick(1'b1, 5'd7, 1'b0, 1'b1);
        expect_out("bp_accept7", 1'b1, 1'b0, 16'd248, 5'd31, 4'd8, 1'b0);
        tick(1'b0, 5'd0, 1'b1, 1'b1);
        expect_out("bp_flush", 1'b1, 1'b0, 16'd248, 5'd31, 4'd8, 1'b0);
        tick(1'b0, 5'd0, 1'b0, 1'b1);
        expect_out("bp_result", 1'b0, 1'b1, 16'd7, 5'd7, 4'd1, 1'b0);

        // Flush after partial block 31,0,5; then a flush with nothing pending.
        tick(1'b1, 5'd31, 1'b0, 1'b1);
        expect_out("fl_s0", 1'b1, 1'b0, 16'd7, 5'd7, 4'd1, 1'b0);
        tick(1'b1, 5'd0, 1'b0, 1'b1);
        tick(1'b1, 5'd5, 1'b0, 1'b1);
        tick(1'b0, 5'd0, 1'b1, 1'b1);
        expect_out("fl_cyc", 1'b1, 1'b0, 16'd7, 5'd7, 4'd1, 1'b0);
        tick(1'b0, 5'd0, 1'b0, 1'b1);
        expect_out("fl_result", 1'b0, 1'b1, 16'd36, 5'd31, 4'd3, 1'b0);
        tick(1'b0, 5'd0, 1'b1, 1'b1);
        expect_out("fl_empty0", 1'b1, 1'b0, 16'd36, 5'd31, 4'd3, 1'b0);
        tick(1'b0, 5'd0, 1'b0, 1'b1);
        expect_out("fl_empty1", 1'b1, 1'b0, 16'd36, 5'd31, 4'd3, 1'b0);

        // Flush coincident with the third sample: 4,9,2 -> 15.
        tick(1'b1, 5'd4, 1'b0, 1'b1);
        tick(1'b1, 5'd9, 1'b0, 1'b1);
        tick(1'b1, 5'd2, 1'b1, 1'b1);
        expect_out("co_cyc", 1'b1, 1'b0, 16'd36, 5'd31, 4'd3, 1'b0);
        tick(1'b0, 5'd0, 1'b0, 1'b1);
        expect_out("co_result", 1'b0, 1'b1, 16'd15, 5'd9, 4'd3, 1'b0);
        tick(1'b0, 5'd0, 1'b0, 1'b1);
        expect_out("co_after", 1'b1, 1'b0, 16'd15, 5'd9, 4'd3, 1'b0);

        // Reset mid-block after five samples.
        for (int i = 0; i < 5; i++) tick(1'b1, 5'd1, 1'b0, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        bus.in_valid = 1'b0;
        #1 expect_out("rst_mid", 1'b1, 1'b0, 16'd0, 5'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 5'd2, 1'b0, 1'b0);
            expect_out($sformatf("rst_blk[%0d]", i), 1'b1, 1'b0, 16'd0, 5'd0, 4'd0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 5'd0, 1'b0, 1'b0);
            expect_out($sformatf("rst_hold[%0d]", i), 1'b0, 1'b1, 16'd16, 5'd2, 4'd8, 1'b0);
        end

        // Reset during HOLD with out_ready=0.
        #2 rst = 1'b1;
        #1 expect_out("rst_hold", 1'b1, 1'b0, 16'd0, 5'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 5'd6, 1'b0, 1'b1);
        expect_out("rst_next0", 1'b1, 1'b0, 16'd0, 5'd0, 4'd0, 1'b0);
        tick(1'b0, 5'd0, 1'b1, 1'b1);
        tick(1'b0, 5'd0, 1'b0, 1'b1);
        expect_out("rst_next", 1'b0, 1'b1, 16'd6, 5'd6, 4'd1, 1'b0);

        // Saturation at ACC_W=6: 8 x 30 clamps at 63.
        for (int i = 0; i < 8; i++) begin
            tick6(1'b1, 5'd30, 1'b0, 1'b1);
            expect6($sformatf("sat_in[%0d]", i), 1'b1, 1'b0, 6'd0, 5'd0, 4'd0, 1'b0);
        end
        tick6(1'b0, 5'd0, 1'b0, 1'b1);
        expect6("sat_result", 1'b0, 1'b1, 6'd63, 5'd30, 4'd8, 1'b1);

        // 31+31+1 lands exactly on 63 without overflow; 31+31+2 overflows.
        tick6(1'b1, 5'd31, 1'b0, 1'b1);
        expect6("sat_clean0", 1'b1, 1'b0, 6'd63, 5'd30, 4'd8, 1'b1);
        tick6(1'b1, 5'd31, 1'b0, 1'b1);
        tick6(1'b1, 5'd1, 1'b1, 1'b1);
        tick6(1'b0, 5'd0, 1'b0, 1'b1);
        expect6("sat_edge63", 1'b0, 1'b1, 6'd63, 5'd31, 4'd3, 1'b0);
        tick6(1'b1, 5'd31, 1'b0, 1'b1);
        tick6(1'b1, 5'd31, 1'b0, 1'b1);
        tick6(1'b1, 5'd2, 1'b1, 1'b1);
        tick6(1'b0, 5'd0, 1'b0, 1'b1);
        expect6("sat_edge64", 1'b0, 1'b1, 6'd63, 5'd31, 4'd3, 1'b1);
        tick6(1'b0, 5'd0, 1'b0, 1'b1);
        expect6("sat_after", 1'b1, 1'b0, 6'd63, 5'd31, 4'd3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
